// File: rtl/input_debounce.sv
// input_debounce
//   Conditions a raw asynchronous 1-bit input before it reaches the capture
//   flop. The input is synchronised through a flop chain. A new level must then
//   hold for STABLE_CYCLES consecutive sampled cycles before the debounced
//   output follows it. Shorter pulses are rejected and counted.
//
//   State table:
//     state       | meaning
//     ST_STABLE   | synchronised input agrees with o, or o was just updated
//     ST_PENDING  | synchronised input differs from o; cnt counts how long
//
//   Ports:
//     clk         single clock, all state on posedge
//     rst         synchronous reset, active-high
//     i           raw input, asynchronous to clk
//     o           debounced level (flop)
//     rise        1-cycle pulse in the cycle o becomes 1
//     fall        1-cycle pulse in the cycle o becomes 0
//     glitch_cnt  saturating count of rejected pulses
module input_debounce #(
   parameter int   SYNC_STAGES   = 2,
   parameter int   STABLE_CYCLES = 4,
   parameter logic INIT_VAL      = 1'b0,
   parameter int   GLITCH_W      = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i,
   output logic                o,
   output logic                rise,
   output logic                fall,
   output logic [GLITCH_W-1:0] glitch_cnt
);

   localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   o_d;
   logic                   glitch_inc;

   // Only the first stage of this chain ever samples i.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{INIT_VAL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_STABLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      o_d        = o;
      glitch_inc = 1'b0;
      case (state_q)
         ST_STABLE: begin
            cnt_d = '0;
            if (s != o) begin
               // A one-cycle qualification window accepts the new level immediately.
               if (STABLE_CYCLES == 1) begin
                  o_d = s;
               end else begin
                  cnt_d   = CNT_W'(1);
                  state_d = ST_PENDING;
               end
            end
         end
         ST_PENDING: begin
            if (s == o) begin
               cnt_d      = '0;
               glitch_inc = 1'b1;
               state_d    = ST_STABLE;
            end else if (cnt_q == CNT_LAST) begin
               o_d     = s;
               cnt_d   = '0;
               state_d = ST_STABLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_STABLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Edge pulses are registered together with o, so they line up with its new value.
   always_ff @(posedge clk) begin
      if (rst) begin
         o    <= INIT_VAL;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         o    <= o_d;
         rise <= o_d & ~o;
         fall <= ~o_d & o;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         glitch_cnt <= '0;
      end else if (glitch_inc && (glitch_cnt != {GLITCH_W{1'b1}})) begin
         glitch_cnt <= glitch_cnt + GLITCH_W'(1);
      end
   end

endmodule

// File: tb/tb_input_debounce.sv
// tb_input_debounce
//   Drives two input_debounce instances from the same input and reset:
//   dut  uses the defaults (SYNC_STAGES=2, STABLE_CYCLES=4), and
//   dut1 uses SYNC_STAGES=3, STABLE_CYCLES=1.
//   A reference model tracks each instance by remembering every sampled input.
//   Each new level is accepted once it has been seen for STABLE_CYCLES
//   consecutive cycles. A run that ends sooner is counted as a glitch.
module tb_input_debounce;

   localparam int   GW   = 8;
   localparam logic INIT = 1'b0;

   logic          clk = 1'b0;
   logic          rst;
   logic          i;
   logic          o0, rise0, fall0;
   logic [GW-1:0] gc0;
   logic          o1, rise1, fall1;
   logic [GW-1:0] gc1;

   always #5 clk = ~clk;

   input_debounce #(
      .SYNC_STAGES(2), .STABLE_CYCLES(4), .INIT_VAL(INIT), .GLITCH_W(GW)
   ) dut (
      .clk(clk), .rst(rst), .i(i), .o(o0), .rise(rise0), .fall(fall0), .glitch_cnt(gc0)
   );

   input_debounce #(
      .SYNC_STAGES(3), .STABLE_CYCLES(1), .INIT_VAL(INIT), .GLITCH_W(GW)
   ) dut1 (
      .clk(clk), .rst(rst), .i(i), .o(o1), .rise(rise1), .fall(fall1), .glitch_cnt(gc1)
   );

   int   n_checks = 0;
   int   n_pass   = 0;

   logic hist[$];
   int   last_rst = -1;
   logic m_o[2];
   logic m_rise[2];
   logic m_fall[2];
   int   m_run[2];
   int   m_gl[2];

   function automatic int sync_of(input int k);
      return (k == 0) ? 2 : 3;
   endfunction

   function automatic int stable_of(input int k);
      return (k == 0) ? 4 : 1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input logic ni, input logic nr);
      int   n;
      int   idx;
      logic s;
      i   = ni;
      rst = nr;
      @(posedge clk);
      n = hist.size();
      hist.push_back(ni);
      for (int k = 0; k < 2; k++) begin
         if (nr) begin
            m_o[k]    = INIT;
            m_rise[k] = 1'b0;
            m_fall[k] = 1'b0;
            m_run[k]  = 0;
            m_gl[k]   = 0;
         end else begin
            // The level seen after the synchroniser is the input from SYNC edges ago,
            // or the reset value if that edge was at or before the last reset.
            idx       = n - sync_of(k);
            s         = (idx <= last_rst) ? INIT : hist[idx];
            m_rise[k] = 1'b0;
            m_fall[k] = 1'b0;
            if (s != m_o[k]) begin
               m_run[k]++;
               if (m_run[k] >= stable_of(k)) begin
                  m_o[k]    = s;
                  m_rise[k] = s;
                  m_fall[k] = ~s;
                  m_run[k]  = 0;
               end
            end else begin
               if (m_run[k] > 0 && m_gl[k] < (1 << GW) - 1) m_gl[k]++;
               m_run[k] = 0;
            end
         end
      end
      if (nr) last_rst = n;
      #1;
      check("m_o0",    o0,    m_o[0]);
      check("m_rise0", rise0, m_rise[0]);
      check("m_fall0", fall0, m_fall[0]);
      check("m_gc0",   gc0,   m_gl[0]);
      check("m_o1",    o1,    m_o[1]);
      check("m_rise1", rise1, m_rise[1]);
      check("m_fall1", fall1, m_fall[1]);
      check("m_gc1",   gc1,   m_gl[1]);
      check("excl0",   rise0 & fall0, 0);
      check("excl1",   rise1 & fall1, 0);
   endtask

   initial begin
      int   remaining;
      logic lvl;
      i   = 1'b0;
      rst = 1'b1;

      // Reset with i=1, then release: o rises on the 6th edge after reset.
      for (int t = 0; t < 3; t++) tick(1'b1, 1'b1);
      check("t1_rst_o",  o0,  0);
      check("t1_rst_gc", gc0, 0);
      check("t1_rst_rise", rise0, 0);
      for (int t = 1; t <= 7; t++) begin
         tick(1'b1, 1'b0);
         check("t1_o",    o0,    (t >= 6));
         check("t1_rise", rise0, (t == 6));
         check("t1_fall", fall0, 0);
      end

      // Clean step 0->1.
      for (int t = 0; t < 10; t++) tick(1'b0, 1'b0);
      for (int t = 1; t <= 8; t++) begin
         tick(1'b1, 1'b0);
         check("t2_o",     o0,    (t >= 6));
         check("t2_rise",  rise0, (t == 6));
         check("t2_fall",  fall0, 0);
         check("t6_o1",    o1,    (t >= 4));
         check("t6_rise1", rise1, (t == 4));
      end

      // A single 3-cycle glitch.
      for (int t = 0; t < 10; t++) tick(1'b0, 1'b0);
      for (int t = 1; t <= 9; t++) begin
         tick((t <= 3), 1'b0);
         check("t3_o",    o0,    0);
         check("t3_rise", rise0, 0);
      end
      check("t3_gc1", gc0, 1);
      check("t3_gc_sc1", gc1, 0);

      // 299 more glitches: counter saturates.
      for (int g = 0; g < 299; g++) begin
         for (int t = 0; t < 3; t++) tick(1'b1, 1'b0);
         for (int t = 0; t < 3; t++) tick(1'b0, 1'b0);
      end
      for (int t = 0; t < 6; t++) tick(1'b0, 1'b0);
      check("t3_sat", gc0, 255);

      // 4-cycle pulse accepted, 3-cycle pulse rejected.
      for (int t = 0; t < 10; t++) tick(1'b0, 1'b0);
      for (int t = 1; t <= 12; t++) begin
         tick((t <= 4), 1'b0);
         check("t4_acc_o", o0, (t >= 6 && t <= 9));
      end
      for (int t = 0; t < 6; t++) tick(1'b0, 1'b0);
      for (int t = 1; t <= 12; t++) begin
         tick((t <= 3), 1'b0);
         check("t4_rej_o", o0, 0);
      end

      // Reset while pending with cnt=2.
      for (int t = 0; t < 6; t++) tick(1'b0, 1'b0);
      for (int t = 0; t < 4; t++) tick(1'b1, 1'b0);
      tick(1'b1, 1'b1);
      check("t5_rst_o",  o0,  0);
      check("t5_rst_gc", gc0, 0);
      tick(1'b1, 1'b1);
      for (int t = 1; t <= 8; t++) begin
         tick(1'b0, 1'b0);
         check("t5_o",    o0,    0);
         check("t5_rise", rise0, 0);
         check("t5_gc",   gc0,   0);
      end

      // One-cycle pulse passes through the STABLE_CYCLES=1 instance.
      for (int t = 0; t < 6; t++) tick(1'b0, 1'b0);
      for (int t = 1; t <= 8; t++) begin
         tick((t == 1), 1'b0);
         check("t6_p_o1",    o1,    (t == 4));
         check("t6_p_rise1", rise1, (t == 4));
         check("t6_p_fall1", fall1, (t == 5));
         check("t6_p_o0",    o0,    0);
      end

      // Random runs of random length with occasional resets.
      remaining = 0;
      lvl       = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (remaining == 0) begin
            lvl       = 1'($urandom_range(0, 1));
            remaining = int'($urandom_range(1, 9));
         end
         tick(lvl, ($urandom_range(0, 199) == 0));
         remaining--;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
